// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle (AR, R, AW, W, B) between a master and the on-chip memory responder.
// Latency: none, wires only.
// Backpressure: carries the standard valid/ready pairs of every channel.
interface axi4_mem_responder_if #(
  parameter int DATA_BITS = 512,
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4
);
  localparam int STRB_BITS = DATA_BITS / 8;

  // read address channel
  logic [ID_BITS-1:0]   arid;
  logic [ADDR_BITS-1:0] araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arlock;
  logic [3:0]           arcache;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;

  // read data channel
  logic [ID_BITS-1:0]   rid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  // write address channel
  logic [ID_BITS-1:0]   awid;
  logic [ADDR_BITS-1:0] awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awlock;
  logic [3:0]           awcache;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;

  // write data channel
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  // write response channel
  logic [ID_BITS-1:0]   bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 INCR-burst slave over a dual-port RAM; one read and one write burst in flight at once.
// Latency: AR accept -> first rvalid 2 cycles; last W beat -> bvalid 1 cycle.
// Backpressure: 2-entry read buffer keeps 1 beat/cycle and holds R outputs under !rready.
// Optional: AXI4_MEM_RESP_ERR_EN enables range/size/wlast checking with SLVERR responses.
module axi4_mem_responder #(
  parameter int DATA_BITS = 512,
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4_mem_responder_if.slave  s_axi
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int ADDR_LSB  = $clog2(STRB_BITS);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam int HI_LSB    = ADDR_LSB + IDX_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ------------------------------------------------------------------
  // storage
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  logic [DATA_BITS-1:0] rb_dat [2];

  // ------------------------------------------------------------------
  // read side state
  // ------------------------------------------------------------------
  typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_e;

  r_state_e             r_state_q, r_state_d;
  logic [ID_BITS-1:0]   r_id_q, r_id_d;
  logic [7:0]           r_len_q, r_len_d;
  logic [8:0]           r_iss_q, r_iss_d;      // beats already fetched from RAM
  logic [IDX_BITS-1:0]  r_idx_q, r_idx_d;      // next word to fetch
  logic                 r_err_q, r_err_d;      // sticky: remaining beats are error beats
  logic [1:0]           r_cnt_q, r_cnt_d;      // buffer occupancy, 0..2
  logic                 r_wp_q, r_wp_d;
  logic                 r_rp_q, r_rp_d;
  logic [1:0]           rb_last_q, rb_last_d;
  logic [1:0]           rb_err_q, rb_err_d;
  logic                 arready_q, arready_d;

  logic r_vld, r_pop, r_issue, ar_hs;
  logic ar_err, r_wrap;

  // ------------------------------------------------------------------
  // write side state
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e             w_state_q, w_state_d;
  logic [ID_BITS-1:0]   w_id_q, w_id_d;
  logic [7:0]           w_len_q, w_len_d;
  logic [7:0]           w_cnt_q, w_cnt_d;
  logic [IDX_BITS-1:0]  w_idx_q, w_idx_d;
  logic                 w_aerr_q, w_aerr_d;    // sticky: remaining beats are out of range
  logic                 w_err_q, w_err_d;      // accumulated response error
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;

  logic aw_hs, w_hs, b_hs, w_last_beat, w_we;
  logic aw_err, w_wrap, w_last_mis;

  // ------------------------------------------------------------------
  // error detection (compiled out by default: everything wraps, all OKAY)
  // ------------------------------------------------------------------
`ifdef AXI4_MEM_RESP_ERR_EN
  assign ar_err     = ((s_axi.araddr >> HI_LSB) != '0) || (s_axi.arsize != 3'(ADDR_LSB));
  assign aw_err     = ((s_axi.awaddr >> HI_LSB) != '0) || (s_axi.awsize != 3'(ADDR_LSB));
  assign r_wrap     = (r_idx_q == '1);
  assign w_wrap     = (w_idx_q == '1);
  assign w_last_mis = (s_axi.wlast != w_last_beat);
`else
  assign ar_err     = 1'b0;
  assign aw_err     = 1'b0;
  assign r_wrap     = 1'b0;
  assign w_wrap     = 1'b0;
  assign w_last_mis = 1'b0;
`endif

  // Fields this responder deliberately ignores.
  logic unused_sig;
  assign unused_sig = ^{s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                        s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot,
                        s_axi.araddr, s_axi.awaddr, s_axi.arsize, s_axi.awsize,
                        s_axi.wlast};

  // ------------------------------------------------------------------
  // read channel
  // ------------------------------------------------------------------
  assign ar_hs   = s_axi.arvalid && arready_q;
  assign r_vld   = (r_cnt_q != 2'd0);
  assign r_pop   = r_vld && s_axi.rready;
  // Fetch while beats remain and a slot is (or is about to become) free.
  assign r_issue = (r_state_q == R_BURST) && (r_iss_q <= {1'b0, r_len_q}) &&
                   ((r_cnt_q != 2'd2) || r_pop);

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rid     = r_id_q;
  assign s_axi.rlast   = r_vld && rb_last_q[r_rp_q];
  assign s_axi.rresp   = (r_vld && rb_err_q[r_rp_q]) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rdata   = (r_vld && !rb_err_q[r_rp_q]) ? rb_dat[r_rp_q] : '0;

  // Read FSM state and read-side control registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_iss_q   <= '0;
      r_idx_q   <= '0;
      r_err_q   <= 1'b0;
      r_cnt_q   <= '0;
      r_wp_q    <= 1'b0;
      r_rp_q    <= 1'b0;
      rb_last_q <= '0;
      rb_err_q  <= '0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_iss_q   <= r_iss_d;
      r_idx_q   <= r_idx_d;
      r_err_q   <= r_err_d;
      r_cnt_q   <= r_cnt_d;
      r_wp_q    <= r_wp_d;
      r_rp_q    <= r_rp_d;
      rb_last_q <= rb_last_d;
      rb_err_q  <= rb_err_d;
      arready_q <= arready_d;
    end
  end

  // Read FSM next state: leave the burst when the rlast beat is taken.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_pop && rb_last_q[r_rp_q]) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read datapath: capture AR, advance the fetch index, track buffer slots.
  always_comb begin
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_iss_d   = r_iss_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    r_wp_d    = r_wp_q;
    r_rp_d    = r_rp_q;
    rb_last_d = rb_last_q;
    rb_err_d  = rb_err_q;
    if (ar_hs) begin
      r_id_d  = s_axi.arid;
      r_len_d = s_axi.arlen;
      r_iss_d = '0;
      r_idx_d = s_axi.araddr[ADDR_LSB +: IDX_BITS];
      r_err_d = ar_err;
    end
    if (r_issue) begin
      rb_last_d[r_wp_q] = (r_iss_q == {1'b0, r_len_q});
      rb_err_d[r_wp_q]  = r_err_q;
      r_wp_d            = ~r_wp_q;
      r_iss_d           = r_iss_q + 9'd1;
      r_idx_d           = r_idx_q + IDX_BITS'(1);
      if (r_wrap) r_err_d = 1'b1;
    end
    if (r_pop) r_rp_d = ~r_rp_q;
    r_cnt_d = r_cnt_q + {1'b0, r_issue} - {1'b0, r_pop};
  end

  // Read FSM outputs: arready is a registered decode of the next state.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
  end

  // ------------------------------------------------------------------
  // write channel
  // ------------------------------------------------------------------
  assign aw_hs       = s_axi.awvalid && awready_q;
  assign w_hs        = s_axi.wvalid && wready_q;
  assign b_hs        = bvalid_q && s_axi.bready;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_we        = w_hs && !w_aerr_q && aresetn;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // Write FSM state and write-side control registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_aerr_q  <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_aerr_q  <= w_aerr_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Write FSM next state: the beat counter, not wlast, ends the data phase.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write datapath: capture AW, count beats, accumulate the response error.
  always_comb begin
    w_id_d   = w_id_q;
    w_len_d  = w_len_q;
    w_cnt_d  = w_cnt_q;
    w_idx_d  = w_idx_q;
    w_aerr_d = w_aerr_q;
    w_err_d  = w_err_q;
    if (aw_hs) begin
      w_id_d   = s_axi.awid;
      w_len_d  = s_axi.awlen;
      w_cnt_d  = '0;
      w_idx_d  = s_axi.awaddr[ADDR_LSB +: IDX_BITS];
      w_aerr_d = aw_err;
      w_err_d  = 1'b0;
    end
    if (w_hs) begin
      w_cnt_d = w_cnt_q + 8'd1;
      w_idx_d = w_idx_q + IDX_BITS'(1);
      if (w_wrap) w_aerr_d = 1'b1;
      if (w_aerr_q || w_last_mis) w_err_d = 1'b1;
    end
  end

  // Write FSM outputs: handshake signals are registered decodes of the next state.
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // ------------------------------------------------------------------
  // RAM: byte-masked write port, read port fetching straight into the R buffer.
  // A same-cycle read of the word being written sees the old contents.
  // ------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
    if (r_issue) rb_dat[r_wp_q] <= mem[r_idx_q];
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: write/readback, strobes, backpressure,
// concurrency, index wrap (or SLVERR with AXI4_MEM_RESP_ERR_EN) and reset mid-burst.
// Expected data comes from a bench-side shadow memory updated on every written beat.
module tb_axi4_mem_responder;
  localparam int DB    = 512;
  localparam int AB    = 32;
  localparam int IB    = 4;
  localparam int DEPTH = 1024;
  localparam int NB    = DB / 8;
`ifdef AXI4_MEM_RESP_ERR_EN
  localparam int WRAP_ERR_FROM = 1;
`else
  localparam int WRAP_ERR_FROM = 256;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_mem_responder_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .ID_BITS(IB)) axi ();

  axi4_mem_responder #(.DATA_BITS(DB), .ADDR_BITS(AB), .ID_BITS(IB), .MEM_DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (axi.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] model   [DEPTH];
  logic [DB-1:0] wr_dat  [256];
  logic [NB-1:0] wr_strb [256];
  logic [DB-1:0] beat_dat [256];

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [AB-1:0] addr, input logic [7:0] len, input logic [IB-1:0] id);
    int n = 0;
    axi.awaddr = addr; axi.awlen = len; axi.awid = id; axi.awsize = 3'd6; axi.awburst = 2'b01;
    axi.awvalid = 1'b1;
    while (!axi.awready && n < 100) begin step(); n++; end
    if (n >= 100) check("aw_timeout", DB'(0), DB'(1));
    step();
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [AB-1:0] addr, input logic [7:0] len, input logic [IB-1:0] id);
    int n = 0;
    axi.araddr = addr; axi.arlen = len; axi.arid = id; axi.arsize = 3'd6; axi.arburst = 2'b01;
    axi.arvalid = 1'b1;
    while (!axi.arready && n < 100) begin step(); n++; end
    if (n >= 100) check("ar_timeout", DB'(0), DB'(1));
    step();
    axi.arvalid = 1'b0;
  endtask

  // Sends wr_dat/wr_strb[0..len] and mirrors each accepted beat into the model.
  task automatic w_send(input int idx, input int len);
    int n;
    for (int k = 0; k <= len; k++) begin
      axi.wdata = wr_dat[k]; axi.wstrb = wr_strb[k]; axi.wlast = (k == len); axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 100) begin step(); n++; end
      if (n >= 100) check("w_timeout", DB'(0), DB'(1));
      step();
      for (int b = 0; b < NB; b++)
        if (wr_strb[k][b]) model[(idx + k) % DEPTH][b*8 +: 8] = wr_dat[k][b*8 +: 8];
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic b_recv(input logic [IB-1:0] id);
    int n = 0;
    axi.bready = 1'b1;
    while (!axi.bvalid && n < 100) begin step(); n++; end
    if (n >= 100) check("b_timeout", DB'(0), DB'(1));
    check("bid", DB'(axi.bid), DB'(id));
    check("bresp", DB'(axi.bresp), DB'(0));
    step();
    axi.bready = 1'b0;
  endtask

  task automatic wr_burst(input logic [AB-1:0] addr, input int len, input logic [IB-1:0] id);
    aw_send(addr, 8'(len), id);
    w_send(int'(addr[15:6]), len);
    b_recv(id);
  endtask

  // Reads len+1 beats; alt=1 toggles rready 1,0,1,0. Every cycle rvalid is high the
  // presented beat is compared with the model, so stalled beats are checked too.
  task automatic rd_burst(input logic [AB-1:0] addr, input int len, input logic [IB-1:0] id,
                          input bit alt, input int err_from, input bit lat);
    int k = 0, n = 0, first = -1;
    int idx0;
    logic [DB-1:0] exp;
    idx0 = int'(addr[15:6]);
    ar_send(addr, 8'(len), id);
    if (lat) check("r_lat_t1", DB'(axi.rvalid), DB'(0));
    while (k <= len && n < 400) begin
      axi.rready = alt ? ((n % 2) == 0) : 1'b1;
      if (axi.rvalid) begin
        if (first < 0) first = n;
        exp = (k >= err_from) ? '0 : model[(idx0 + k) % DEPTH];
        check("rdata", axi.rdata, exp);
        check("rid", DB'(axi.rid), DB'(id));
        check("rresp", DB'(axi.rresp), DB'((k >= err_from) ? 2 : 0));
        check("rlast", DB'(axi.rlast), DB'(k == len));
        if (axi.rready) begin
          beat_dat[k] = axi.rdata;
          k++;
        end
      end
      step();
      n++;
    end
    axi.rready = 1'b0;
    check("r_beats", DB'(k), DB'(len + 1));
    check("r_no_extra", DB'(axi.rvalid), DB'(0));
    check("arready_turn", DB'(axi.arready), DB'(1));
    if (lat) check("r_lat_t2", DB'(first), DB'(1));
  endtask

  initial begin
    int n, k;
    axi.arvalid = 0; axi.araddr = '0; axi.arlen = '0; axi.arid = '0; axi.arsize = 3'd6;
    axi.arburst = 2'b01; axi.arlock = 0; axi.arcache = '0; axi.arprot = '0; axi.rready = 0;
    axi.awvalid = 0; axi.awaddr = '0; axi.awlen = '0; axi.awid = '0; axi.awsize = 3'd6;
    axi.awburst = 2'b01; axi.awlock = 0; axi.awcache = '0; axi.awprot = '0;
    axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0; axi.bready = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // reset values
    aresetn = 1'b0;
    repeat (3) step();
    check("rst_arready", DB'(axi.arready), DB'(0));
    check("rst_awready", DB'(axi.awready), DB'(0));
    check("rst_rvalid", DB'(axi.rvalid), DB'(0));
    check("rst_wready", DB'(axi.wready), DB'(0));
    check("rst_bvalid", DB'(axi.bvalid), DB'(0));
    check("rst_rlast", DB'(axi.rlast), DB'(0));
    check("rst_rdata", axi.rdata, '0);
    check("rst_bresp", DB'(axi.bresp), DB'(0));
    aresetn = 1'b1;
    step();
    check("rel_arready", DB'(axi.arready), DB'(1));
    check("rel_awready", DB'(axi.awready), DB'(1));

    // write 4 beats 0xA0..A3 to 0x0, id 5, with handshake timing checks
    for (int i = 0; i < 4; i++) begin wr_dat[i] = {NB{8'(8'hA0 + i)}}; wr_strb[i] = '1; end
    aw_send(32'h0, 8'd3, 4'd5);
    check("wready_t1", DB'(axi.wready), DB'(1));
    check("awready_busy", DB'(axi.awready), DB'(0));
    w_send(0, 3);
    check("bvalid_rise", DB'(axi.bvalid), DB'(1));
    b_recv(4'd5);
    check("awready_turn", DB'(axi.awready), DB'(1));
    check("bvalid_fall", DB'(axi.bvalid), DB'(0));

    // read back, id 2, with latency check
    rd_burst(32'h0, 3, 4'd2, 1'b0, 256, 1'b1);
    check("rb_beat0_abs", beat_dat[0], {NB{8'hA0}});
    check("rb_beat3_abs", beat_dat[3], {NB{8'hA3}});

    // partial strobe at 0x40
    wr_dat[0] = {NB{8'hFF}}; wr_strb[0] = '1;
    wr_burst(32'h40, 0, 4'd1);
    wr_dat[0] = '0; wr_strb[0] = 64'hF;
    wr_burst(32'h40, 0, 4'd1);
    rd_burst(32'h40, 0, 4'd3, 1'b0, 256, 1'b0);
    check("strobe_abs", beat_dat[0], {{(NB-4){8'hFF}}, 32'h0});

    // backpressure: 16 beats at 0x2000, rready 1,0,1,0
    for (int i = 0; i < 16; i++) begin wr_dat[i] = {16{32'hC0DE0000 + 32'(i)}}; wr_strb[i] = '1; end
    wr_burst(32'h2000, 15, 4'd7);
    rd_burst(32'h2000, 15, 4'd8, 1'b1, 256, 1'b0);
    check("bp_beat15_abs", beat_dat[15], {16{32'hC0DE000F}});

    // concurrency: fill words 4..7, then 8-beat write to 0x1000 alongside 8-beat read of 0x0
    for (int i = 0; i < 4; i++) begin wr_dat[i] = {16{32'h5000_0000 + 32'(i)}}; wr_strb[i] = '1; end
    wr_burst(32'h100, 3, 4'd2);
    for (int i = 0; i < 8; i++) begin wr_dat[i] = {16{32'h7700_0000 + 32'(i)}}; wr_strb[i] = '1; end
    fork
      wr_burst(32'h1000, 7, 4'd9);
      rd_burst(32'h0, 7, 4'd10, 1'b0, 256, 1'b0);
    join
    rd_burst(32'h1000, 7, 4'd11, 1'b0, 256, 1'b0);

    // wrap at top of memory: word 1023 then word 0
    wr_dat[0] = {NB{8'h5A}}; wr_strb[0] = '1;
    wr_burst(32'hFFC0, 0, 4'd4);
    rd_burst(32'hFFC0, 1, 4'd6, 1'b0, WRAP_ERR_FROM, 1'b0);

    // reset during beat 3 of an 8-beat read
    ar_send(32'h0, 8'd7, 4'd3);
    axi.rready = 1'b1;
    k = 0; n = 0;
    while (k < 2 && n < 50) begin
      if (axi.rvalid) k++;
      step();
      n++;
    end
    check("mid_beats", DB'(k), DB'(2));
    aresetn = 1'b0;
    step();
    axi.rready = 1'b0;
    check("mid_rvalid", DB'(axi.rvalid), DB'(0));
    check("mid_arready", DB'(axi.arready), DB'(0));
    aresetn = 1'b1;
    step();
    check("mid_rel_arready", DB'(axi.arready), DB'(1));
    rd_burst(32'h0, 3, 4'd12, 1'b0, 256, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave responder backed by on-chip dual-port memory: the far end of the aligned CDMA's AXI4 master port. It accepts INCR read and write bursts, returns read data and write responses with full AXI4 handshaking, and serves one read and one write burst concurrently. It stands in for DDR in block-level benches and serves as a small on-chip scratch target in MLO builds.

## Interface
- DATA_BITS, AXI_DATA_BITS: data bus width; power of two, ≥32.
- ADDR_BITS, AXI_ADDR_BITS: address width.
- ID_BITS, AXI_ID_BITS: ID width.
- MEM_DEPTH, 1024: memory depth in DATA_BITS words; power of two.
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low, on aclk.
- s_axi  AXI4.slave  interface  AR, R, AW, W and B channels, widths from the parameters above.

## Operation
- Derived constants: ADDR_LSB = log2(DATA_BITS/8); word index = addr[ADDR_LSB +: log2(MEM_DEPTH)].
- Address arithmetic: full-width INCR only; the index increments by 1 per beat; 4 KB crossing is not checked.
- Ignored fields: arburst/awburst, lock, cache and prot.
- Memory: read port and write port are independent. A same-cycle read and write of one word returns the old data. Memory contents are not reset.
- Read FSM states: R_IDLE, R_BURST.
  - R_IDLE: arready=1. An AR handshake captures arid, arlen and the start index, then moves to R_BURST.
  - R_BURST: the memory is read one cycle ahead into a 2-entry output buffer, so data keeps flowing under backpressure.
  - R beats: rid = captured ID; rresp = OKAY; rlast on beat arlen.
  - The R handshake with rlast returns the FSM to R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. An AW handshake captures awid, awlen and the index, then moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the word with byte enables = wstrb. A beat counter governs termination; wlast is not used for control.
  - The handshake of beat awlen moves to W_RESP.
  - W_RESP: bvalid=1, bid = captured ID, bresp = OKAY. The B handshake returns to W_IDLE.
- Out-of-range index (address bits above the word index nonzero, or index incremented past MEM_DEPTH-1): wraps modulo MEM_DEPTH. See Configuration.
- Reset at any point: both FSMs return to idle; in-flight bursts are abandoned with no response; buffered read data is discarded.

## Timing
- Reset values: arready=0, awready=0, rvalid=0, wready=0, bvalid=0, rlast=0, rid/bid/rresp/bresp/rdata=0.
- First cycle after aresetn rises: arready=1 and awready=1.
- Read latency: AR handshake in cycle T gives the first rvalid in T+2.
- Read throughput: 1 beat/cycle while rready=1.
- Read backpressure: rdata, rid, rresp and rlast hold stable while rvalid && !rready. No beat is dropped or duplicated.
- Read turnaround: arready reasserts the cycle after the rlast handshake.
- Write timing:
  - AW handshake in cycle T: wready=1 from T+1.
  - A write in cycle C is visible to a read port access in C+1.
  - bvalid rises the cycle after the last W handshake.
  - awready reasserts the cycle after the B handshake.
- Valid signals never depend combinationally on ready signals. arready, awready and wready are registered FSM decodes.

## Configuration
- AXI4_MEM_RESP_ERR_EN defined: error checking is enabled.
  - Any out-of-range beat, or arsize/awsize ≠ ADDR_LSB, is flagged as an error.
  - Read error beat: rresp=SLVERR (2'b10), rdata=0.
  - Write error beat: the memory write is suppressed and bresp=SLVERR.
  - Write, wlast mismatch: wlast on any beat other than the last, or missing on the last beat, sets bresp=SLVERR.
- AXI4_MEM_RESP_ERR_EN undefined: indices wrap modulo MEM_DEPTH; all responses are OKAY; wlast and size are ignored.

## Test plan
- Write then read back (DATA_BITS=512):
  - Stimulus: AW addr 0x0, len 3, awid 5; beats 0xA0..A3 replicated, wstrb all ones; then AR 0x0, len 3, arid 2.
  - Required: bvalid with bid=5, bresp=0; 4 R beats equal to the written data, rid=2, rlast only on beat 4.
- Partial strobe:
  - Stimulus: 0x40 holds all 0xFF; write 0x40 with data 0, wstrb=0xF.
  - Required: readback bytes 0-3 = 0x00, bytes 4-63 = 0xFF.
- Backpressure:
  - Stimulus: 16-beat read; rready pattern 1,0,1,0….
  - Required: exactly 16 beats in address order; outputs stable during stalls; rlast on beat 16.
- Concurrency:
  - Stimulus: 8-beat write to 0x1000 and 8-beat read of 0x0 issued in the same cycle.
  - Required: both complete with no stall coupling; read data equals prior contents.
- Wrap/error (MEM_DEPTH=1024):
  - Stimulus: AR 0xFFC0, len 1.
  - Required without macro: beat 2 = word 0, rresp OKAY.
  - Required with AXI4_MEM_RESP_ERR_EN: beat 2 rresp=2'b10, rdata=0.
- Reset mid-burst:
  - Stimulus: drop aresetn on beat 3 of an 8-beat read.
  - Required: rvalid=0 the next cycle; arready=1 the first cycle after release; a fresh 4-beat read returns correct data.
